asyn_fifo_write_arbiter: RTL and testbench
==========================================

# asyn_fifo_write_arbiter

- Shares the single write port of the asynchronous FIFO (Push/DataIn/full, Wclk domain) between NumReq independent requesters.
- Round-robin arbitration with an optional burst lock: a winner keeps the port for up to BurstLen consecutive words.
- Sits entirely in the write clock domain, directly in front of the FIFO write side.
- Guarantees no push is ever issued while full is high.

## Interface
Parameters:
- DataSize, 3: FIFO word width in bits.
- NumReq, 4: number of requesters, 2..8.
- BurstLen, 4: maximum consecutive words per grant, 1..16. BurstLen=1 gives pure round-robin.

Ports:
- Wclk  input  1  write-domain clock. Single clock for the block.
- Wresetn  input  1  reset, asynchronous, active-low.
- Req  input  NumReq  per-requester valid. Req[i] and its ReqData slice are held until granted.
- ReqData  input  NumReq*DataSize  requester data. Slice i is ReqData[i*DataSize +: DataSize].
- Gnt  output  NumReq  one-hot or zero ready. A transfer for requester i occurs at a Wclk rising edge with Req[i]&Gnt[i].
- full  input  1  FIFO full flag, Wclk domain.
- Push  output  1  FIFO write enable.
- DataIn  output  DataSize  FIFO write data.
- Busy  output  1  high while in LOCK.

## Operation
State registers:
- State: IDLE or LOCK.
- Ptr: priority pointer, clog2(NumReq) bits.
- Owner: clog2(NumReq) bits.
- BurstCnt: clog2(BurstLen)+1 bits.

Gnt, Push and DataIn are combinational from the state and inputs, giving same-cycle acceptance:
- Push = |(Req & Gnt).
- DataIn = ReqData slice of the granted index, or 0 when Gnt=0.

IDLE:
- If full=1 or Req=0: Gnt=0, no state change.
- Otherwise the winner is the first i with Req[i]=1, scanning Ptr, Ptr+1, ... modulo NumReq. Gnt has only that winner's bit set.
- At the edge, for a winner w:
  - Ptr <= (w+1) mod NumReq.
  - Owner <= w.
  - If BurstLen>1: State <= LOCK and BurstCnt <= 1. Otherwise stay in IDLE.

LOCK:
- Gnt[Owner] = Req[Owner] & ~full. All other Gnt bits are 0. Other requesters wait regardless of priority.
- On a transfer: BurstCnt increments. If the new value equals BurstLen, State <= IDLE.
- If full=1 and Req[Owner]=1: stall. Gnt=0, Push=0, State and BurstCnt hold.
- If Req[Owner]=0: State <= IDLE, Gnt=0 that cycle. This costs one bubble. Ptr already points past Owner.

Invariants:
- Push=1 implies full=0.
- Gnt is never multi-hot.
- Ptr always advances past the last IDLE winner, so every continuously requesting requester is granted within NumReq arbitration rounds.

## Timing
- Reset (Wresetn=0, asynchronous): State=IDLE, Ptr=0, Owner=0, BurstCnt=0.
- Outputs during reset are forced to Gnt=0, Push=0, DataIn=0, Busy=0, independent of inputs.
- Reset asserted mid-burst abandons the burst. There is no partial push, because Push is combinational and forced low.
- Latency: Req[i] to Gnt[i] is 0 cycles when i wins in IDLE or owns the LOCK.
- Throughput: 1 word per cycle within a burst. Back-to-back IDLE grants to different requesters also run at 1 word/cycle.
- A requester may change ReqData and keep Req high in the cycle after a transfer; that is treated as a new word.
- full is sampled in the same cycle as the push decision. The FIFO must present full reflecting all writes up to the previous edge.
- Pointer wrap: (NumReq-1)+1 maps to 0. BurstCnt never exceeds BurstLen.

## Test plan
1. Reset: Wresetn=0 during LOCK with Req=4'b1111 -> Gnt=0, Push=0, Busy=0 immediately. After release with BurstLen=1 -> first Gnt=4'b0001.
2. Round-robin, BurstLen=1, Req=4'b1111 held, full=0 -> Gnt sequence 0001, 0010, 0100, 1000, 0001. Push=1 every cycle. DataIn matches the granted slice each cycle.
3. Burst, BurstLen=4, Req=4'b0011 held -> requester 0 gets 4 consecutive transfers with Busy=1, then requester 1 gets 4. No bubble between bursts.
4. Full stall: full=1 after the 2nd word of a 4-word burst, held 3 cycles -> Gnt=0 and Push=0 for 3 cycles with Busy=1. Then exactly 2 more words for the same owner, then IDLE.
5. Owner drop: BurstLen=4, the owner deasserts Req after 1 word while Req[2]=1 -> one cycle with Gnt=0 and State=IDLE. The next cycle Gnt=4'b0100.
6. Wrap: last winner 3 (Ptr=0), Req=4'b1001 -> Gnt=4'b0001. The next IDLE arbitration with Req=4'b1001 gives Gnt=4'b1000.

Source files
------------

// File: rtl/asyn_fifo_write_arbiter.sv
// Round-robin write-port arbiter with burst lock, placed in front of the async FIFO write side.
// Grant, push and data are combinational so a requester is accepted in the same Wclk cycle.
module asyn_fifo_write_arbiter #(
    parameter int DataSize = 3,
    parameter int NumReq   = 4,
    parameter int BurstLen = 4
) (
    input  logic                         Wclk,
    input  logic                         Wresetn,
    input  logic [NumReq-1:0]            Req,
    input  logic [NumReq*DataSize-1:0]   ReqData,
    output logic [NumReq-1:0]            Gnt,
    input  logic                         full,
    output logic                         Push,
    output logic [DataSize-1:0]          DataIn,
    output logic                         Busy
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = $clog2(BurstLen) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            win_found;
    logic [PtrW-1:0] win_idx;
    logic [PtrW-1:0] cand;
    logic            gnt_vld;
    logic [PtrW-1:0] gnt_idx;

    // First active requester at or after the priority pointer, wrapping modulo NumReq.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = PtrW'((int'(ptr_q) + k) % NumReq);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        case (state_q)
            IDLE: begin
                if (win_found && !full) begin
                    gnt_vld = 1'b1;
                    gnt_idx = win_idx;
                    ptr_d   = (int'(win_idx) == NumReq - 1) ? '0 : win_idx + 1'b1;
                    owner_d = win_idx;
                    if (BurstLen > 1) begin
                        state_d = LOCK;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            LOCK: begin
                // An owner that drops its request releases the lock, costing one empty cycle.
                if (!Req[owner_q]) begin
                    state_d = IDLE;
                end else if (!full) begin
                    gnt_vld = 1'b1;
                    gnt_idx = owner_q;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CntW'(BurstLen)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by reset so an abandoned burst never produces a partial push.
    always_comb begin
        Gnt    = '0;
        Push   = 1'b0;
        DataIn = '0;
        if (Wresetn && gnt_vld) begin
            Gnt[gnt_idx] = 1'b1;
            Push         = 1'b1;
            DataIn       = ReqData[int'(gnt_idx)*DataSize +: DataSize];
        end
    end

    assign Busy = Wresetn && (state_q == LOCK);

    always_ff @(posedge Wclk or negedge Wresetn) begin
        if (!Wresetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_asyn_fifo_write_arbiter.sv
// Bench for asyn_fifo_write_arbiter: a BurstLen=1 and a BurstLen=4 instance, directed cases
// with literal expectations plus randomized requesters checked against a behavioural model.
module tb_asyn_fifo_write_arbiter;

    localparam int DW = 3;
    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstn;
    logic [NR-1:0]    req    [2];
    logic [NR*DW-1:0] rdata  [2];
    logic             full_i [2];
    logic [NR-1:0]    gnt    [2];
    logic             push   [2];
    logic [DW-1:0]    din    [2];
    logic             busy   [2];

    asyn_fifo_write_arbiter #(.DataSize(DW), .NumReq(NR), .BurstLen(1)) u_rr (
        .Wclk(clk), .Wresetn(rstn), .Req(req[0]), .ReqData(rdata[0]), .Gnt(gnt[0]),
        .full(full_i[0]), .Push(push[0]), .DataIn(din[0]), .Busy(busy[0])
    );

    asyn_fifo_write_arbiter #(.DataSize(DW), .NumReq(NR), .BurstLen(4)) u_burst (
        .Wclk(clk), .Wresetn(rstn), .Req(req[1]), .ReqData(rdata[1]), .Gnt(gnt[1]),
        .full(full_i[1]), .Push(push[1]), .DataIn(din[1]), .Busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    // Model: lock flag, owner, priority pointer and words still allowed in the current burst.
    bit m_lock  [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_left  [2];

    bit            lit_en   [2];
    logic [NR-1:0] lit_gnt  [2];
    logic          lit_busy [2];
    logic [DW-1:0] lit_din  [2];

    function automatic int bl(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: actual %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    logic [NR-1:0] eg;
    logic          ep;
    logic [DW-1:0] ed;
    logic          eb;
    int            w;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            eg = '0; ep = 1'b0; ed = '0; eb = 1'b0; w = -1;
            if (!rstn) begin
                m_lock[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0; m_left[k] = 0;
            end else begin
                eb = m_lock[k];
                if (!m_lock[k]) begin
                    if (!full_i[k])
                        for (int s = 0; s < NR; s++)
                            if (w < 0 && req[k][(m_ptr[k] + s) % NR]) w = (m_ptr[k] + s) % NR;
                end else if (req[k][m_owner[k]] && !full_i[k]) begin
                    w = m_owner[k];
                end
                if (w >= 0) begin
                    eg = 4'b0001 << w;
                    ep = 1'b1;
                    ed = DW'(rdata[k] >> (w * DW));
                end
            end
            chk("gnt",  k, 32'(gnt[k]),  32'(eg));
            chk("push", k, 32'(push[k]), 32'(ep));
            chk("din",  k, 32'(din[k]),  32'(ed));
            chk("busy", k, 32'(busy[k]), 32'(eb));
            if (lit_en[k]) begin
                chk("lit_gnt",  k, 32'(gnt[k]),  32'(lit_gnt[k]));
                chk("lit_busy", k, 32'(busy[k]), 32'(lit_busy[k]));
                chk("lit_din",  k, 32'(din[k]),  32'(lit_din[k]));
            end
            if (rstn) begin
                if (!m_lock[k]) begin
                    if (w >= 0) begin
                        m_ptr[k]   = (w + 1) % NR;
                        m_owner[k] = w;
                        if (bl(k) > 1) begin
                            m_lock[k] = 1'b1;
                            m_left[k] = bl(k) - 1;
                        end
                    end
                end else if (!req[k][m_owner[k]]) begin
                    m_lock[k] = 1'b0;
                end else if (w >= 0) begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_lock[k] = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_en[0] = 1'b0;
        lit_en[1] = 1'b0;
    endtask

    task automatic lit(int k, logic [NR-1:0] g, logic b, logic [DW-1:0] d);
        lit_en[k]   = 1'b1;
        lit_gnt[k]  = g;
        lit_busy[k] = b;
        lit_din[k]  = d;
    endtask

    task automatic do_reset();
        cyc();
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = '0; full_i[k] = 1'b0;
            lit(k, '0, 1'b0, '0);
        end
        cyc();
        rstn = 1'b1;
    endtask

    logic [31:0]   pat_g;
    logic [7:0]    pat_b;
    logic [7:0]    pat_f;
    logic [NR-1:0] xf [2];
    logic [NR-1:0] g;
    bit            rst_hold;

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = '0; rdata[k] = '0; full_i[k] = 1'b0; lit_en[k] = 1'b0;
            lit(k, '0, 1'b0, '0);
        end

        // Pure round-robin over all four requesters.
        do_reset();
        rdata[0] = {3'd4, 3'd3, 3'd2, 3'd1};
        req[0] = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            g = 4'b0001 << (c % 4);
            lit(0, g, 1'b0, DW'((c % 4) + 1));
            cyc();
        end

        // Reset asserted while the burst instance is locked.
        do_reset();
        rdata[1] = {3'd4, 3'd3, 3'd2, 3'd1};
        req[1] = 4'b1111;
        lit(1, 4'b0001, 1'b0, 3'd1);
        cyc();
        lit(1, 4'b0001, 1'b1, 3'd1);
        cyc();
        rdata[0] = {3'd4, 3'd3, 3'd2, 3'd1};
        req[0] = 4'b1111;
        #1 rstn = 1'b0;
        lit(0, '0, 1'b0, '0);
        lit(1, '0, 1'b0, '0);
        cyc();
        rstn = 1'b1;
        lit(0, 4'b0001, 1'b0, 3'd1);
        lit(1, 4'b0001, 1'b0, 3'd1);
        cyc();

        // Two back-to-back 4-word bursts.
        do_reset();
        rdata[1] = {3'd0, 3'd0, 3'd6, 3'd5};
        req[1] = 4'b0011;
        for (int c = 0; c < 9; c++) begin
            g = (c >= 4 && c < 8) ? 4'b0010 : 4'b0001;
            lit(1, g, (c % 4) != 0, (g == 4'b0001) ? 3'd5 : 3'd6);
            cyc();
        end

        // Full stall of three cycles after the second word of a burst.
        do_reset();
        rdata[1] = {3'd0, 3'd0, 3'd6, 3'd5};
        req[1] = 4'b0011;
        pat_g = {4'h2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        pat_b = 8'b0111_1110;
        pat_f = 8'b0001_1100;
        for (int c = 0; c < 8; c++) begin
            full_i[1] = pat_f[c];
            g = pat_g[c*4 +: 4];
            lit(1, g, pat_b[c], (g == 4'h1) ? 3'd5 : ((g == 4'h2) ? 3'd6 : 3'd0));
            cyc();
        end

        // Owner drops its request after one word.
        do_reset();
        rdata[1] = {3'd0, 3'd7, 3'd0, 3'd5};
        req[1] = 4'b0101;
        lit(1, 4'b0001, 1'b0, 3'd5);
        cyc();
        req[1] = 4'b0100;
        lit(1, 4'b0000, 1'b1, 3'd0);
        cyc();
        lit(1, 4'b0100, 1'b0, 3'd7);
        cyc();

        // Pointer wrap from requester 3 back to 0.
        do_reset();
        rdata[0] = {3'd4, 3'd3, 3'd2, 3'd1};
        req[0] = 4'b1000;
        lit(0, 4'b1000, 1'b0, 3'd4);
        cyc();
        req[0] = 4'b1001;
        lit(0, 4'b0001, 1'b0, 3'd1);
        cyc();
        lit(0, 4'b1000, 1'b0, 3'd4);
        cyc();

        // Randomized requesters that hold Req and data until granted.
        do_reset();
        rst_hold = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            #1;
            xf[0] = req[0] & gnt[0];
            xf[1] = req[1] & gnt[1];
            cyc();
            if (rst_hold) begin
                rstn = 1'b1;
                rst_hold = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NR; i++) begin
                    if (req[k][i] && xf[k][i]) begin
                        if ($urandom_range(0, 1) == 1) rdata[k][i*DW +: DW] = 3'($urandom);
                        else req[k][i] = 1'b0;
                    end else if (!req[k][i] && $urandom_range(0, 2) == 0) begin
                        req[k][i] = 1'b1;
                        rdata[k][i*DW +: DW] = 3'($urandom);
                    end
                end
                full_i[k] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 399) == 0) begin
                #2 rstn = 1'b0;
                rst_hold = 1'b1;
            end
        end

        rstn = 1'b1;
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
